bus_transfer_seq: RTL and testbench

// - Sequencer and source multiplexer driving the shared datapath bus (BusMuxOut) feeding the 16-entry register file.
// - Accepts register-transfer commands (src code, dst reg) through a valid/ready handshake into a small FIFO.
// - Per command: selects the source onto a registered bus, then pulses the one-hot load enable (R0_in..R15_in) for the destination.

---
 rtl/bus_transfer_seq.sv | 170 +++++++++++++++++
 tb/tb_bus_transfer_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_seq.sv
// bus_transfer_seq: register-transfer sequencer for the shared datapath bus.
// Commands {src, dst} queue in a small FIFO. Each one is served in three
// cycles: IDLE pops it and latches the selected source onto bus_out, DRIVE
// raises the one-hot r_in/done, and LOAD drops them again while the register
// file captures bus_out.
// Optional build macro R0_ZERO_EN: source code 0 reads as constant zero
// instead of R[0]. Without it, R[0] is read like any other register.
module bus_transfer_seq #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [4:0]           cmd_src,
  input  logic [3:0]           cmd_dst,
  input  logic [16*DATA_W-1:0] reg_q,
  input  logic [DATA_W-1:0]    hi_q,
  input  logic [DATA_W-1:0]    lo_q,
  input  logic [DATA_W-1:0]    zhi_q,
  input  logic [DATA_W-1:0]    zlo_q,
  input  logic [DATA_W-1:0]    pc_q,
  input  logic [DATA_W-1:0]    mdr_q,
  input  logic [DATA_W-1:0]    inport_q,
  input  logic [DATA_W-1:0]    csign_q,
  output logic [DATA_W-1:0]    bus_out,
  output logic [15:0]          r_in,
  output logic                 done,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [8:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic [4:0]        head_src;
  logic [3:0]        head_dst;
  logic [3:0]        cur_dst;
  logic [DATA_W-1:0] sel_value;
  logic              sel_invalid;

  // The FIFO head is only consumed when the sequencer is idle. An entry
  // written on the same edge as a pop therefore waits for the next IDLE edge.
  assign cmd_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head_src  = fifo_mem[rd_ptr][8:4];
  assign head_dst  = fifo_mem[rd_ptr][3:0];
  assign busy      = (state != IDLE) || (count != '0);

  // Command storage (payload only, so it is left out of reset)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_src, cmd_dst};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Source multiplexer for the command at the FIFO head
  always_comb begin
    sel_value   = '0;
    sel_invalid = 1'b0;
    if (!head_src[4]) begin
      sel_value = reg_q[32'(head_src[3:0]) * DATA_W +: DATA_W];
`ifdef R0_ZERO_EN
      if (head_src[3:0] == 4'd0) sel_value = '0;
`endif
    end else begin
      case (head_src[3:0])
        4'd0:    sel_value = hi_q;
        4'd1:    sel_value = lo_q;
        4'd2:    sel_value = zhi_q;
        4'd3:    sel_value = zlo_q;
        4'd4:    sel_value = pc_q;
        4'd5:    sel_value = mdr_q;
        4'd6:    sel_value = inport_q;
        4'd7:    sel_value = csign_q;
        default: sel_invalid = 1'b1;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic: every transfer walks IDLE -> DRIVE -> LOAD -> IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = DRIVE;
      DRIVE:   state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered bus value and the one-cycle load enable / done pulse
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus_out <= '0;
      r_in    <= '0;
      done    <= 1'b0;
      cur_dst <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            bus_out <= sel_value;
            cur_dst <= head_dst;
          end
        end
        DRIVE: begin
          r_in <= 16'd1 << cur_dst;
          done <= 1'b1;
        end
        LOAD: begin
          r_in <= '0;
          done <= 1'b0;
        end
        default: begin
          r_in <= '0;
          done <= 1'b0;
        end
      endcase
    end
  end

  // Sticky invalid-source flag; a new error wins over a simultaneous clear
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                    err <= 1'b0;
    else if (pop && sel_invalid) err <= 1'b1;
    else if (err_clr)            err <= 1'b0;
  end

endmodule

// File: tb/tb_bus_transfer_seq.sv
// tb_bus_transfer_seq: randomized bench for bus_transfer_seq.
// The reference model keeps the pending commands in a queue and tracks
// where the current transfer is in its three-cycle life. A register-file
// array fed by the DUT's r_in/bus_out supplies reg_q, as the real datapath would.
// Follows the R0_ZERO_EN macro the same way the design does.
module tb_bus_transfer_seq;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic                 clk;
  logic                 clr;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [4:0]           cmd_src;
  logic [3:0]           cmd_dst;
  logic [16*DATA_W-1:0] reg_q;
  logic [DATA_W-1:0]    hi_q, lo_q, zhi_q, zlo_q, pc_q, mdr_q, inport_q, csign_q;
  logic [DATA_W-1:0]    bus_out;
  logic [15:0]          r_in;
  logic                 done, busy, err, err_clr;

  // Register file seen by the DUT, written only through its r_in/bus_out
  logic [DATA_W-1:0] env_regs [16];

  // Reference model
  logic [DATA_W-1:0] m_regs [16];
  logic [8:0]        m_q [$];
  int                m_phase;
  logic [3:0]        m_dst;
  logic [DATA_W-1:0] m_bus;
  logic [15:0]       m_r_in;
  logic              m_done;
  logic              m_err;
  logic              m_pushed;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bus_transfer_seq #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .reg_q(reg_q),
    .hi_q(hi_q), .lo_q(lo_q), .zhi_q(zhi_q), .zlo_q(zlo_q),
    .pc_q(pc_q), .mdr_q(mdr_q), .inport_q(inport_q), .csign_q(csign_q),
    .bus_out(bus_out), .r_in(r_in), .done(done), .busy(busy),
    .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the register-file array onto the flat reg_q port
  always_comb begin
    for (int i = 0; i < 16; i++) reg_q[i*DATA_W +: DATA_W] = env_regs[i];
  end

  function automatic logic [DATA_W-1:0] src_value(input logic [4:0] s);
    if (s < 5'd16) begin
`ifdef R0_ZERO_EN
      if (s == 5'd0) return '0;
`endif
      return m_regs[s[3:0]];
    end
    case (s)
      5'd16:   return hi_q;
      5'd17:   return lo_q;
      5'd18:   return zhi_q;
      5'd19:   return zlo_q;
      5'd20:   return pc_q;
      5'd21:   return mdr_q;
      5'd22:   return inport_q;
      5'd23:   return csign_q;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_phase = 0;
    m_bus   = '0;
    m_r_in  = '0;
    m_done  = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic set_reg(input int idx, input logic [DATA_W-1:0] v);
    env_regs[idx] = v;
    m_regs[idx]   = v;
  endtask

  task automatic randomize_specials();
    hi_q = $urandom; lo_q = $urandom; zhi_q = $urandom; zlo_q = $urandom;
    pc_q = $urandom; mdr_q = $urandom; inport_q = $urandom; csign_q = $urandom;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // then let the register file capture whatever the DUT enabled
  task automatic step();
    logic [DATA_W-1:0] pre_bus;
    logic [15:0]       pre_r_in;
    logic [8:0]        head;
    logic              err_set;
    pre_bus  = bus_out;
    pre_r_in = r_in;
    err_set  = 1'b0;
    m_pushed = 1'b0;
    if (!clr) begin
      model_reset();
    end else begin
      m_pushed = cmd_valid && (m_q.size() < DEPTH);
      if (m_phase == 0 && m_q.size() != 0) begin
        head    = m_q.pop_front();
        m_bus   = src_value(head[8:4]);
        m_dst   = head[3:0];
        err_set = (head[8:4] >= 5'd24);
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_r_in  = 16'd1 << m_dst;
        m_done  = 1'b1;
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_r_in  = '0;
        m_done  = 1'b0;
        m_regs[m_dst] = m_bus;
        m_phase = 0;
      end
      if (m_pushed) m_q.push_back({cmd_src, cmd_dst});
      if (err_set)      m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
    @(posedge clk);
    if (clr) begin
      for (int i = 0; i < 16; i++) if (pre_r_in[i]) env_regs[i] = pre_bus;
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    cmd_valid = 1'b0;
    while ((m_phase != 0 || m_q.size() != 0) && n < 20) begin
      step();
      n++;
    end
    step();
  endtask

  task automatic test_reset();
    clr = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; err_clr = 1'b0;
    randomize_specials();
    for (int i = 0; i < 16; i++) set_reg(i, $urandom);
    #2 clr = 1'b0;
    #1;
    model_reset();
    checks++; if (bus_out !== '0)   begin errors++; $display("[TB] FAIL reset_bus got=%h exp=0", bus_out); end
    checks++; if (r_in !== '0)      begin errors++; $display("[TB] FAIL reset_r_in got=%h exp=0", r_in); end
    checks++; if (done !== 1'b0)    begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0)     begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", cmd_ready); end
    step();
    step();
    clr = 1'b1;
    step();
  endtask

  task automatic test_single_move();
    pc_q = 32'h0000_1234;
    cmd_valid = 1'b1; cmd_src = 5'd20; cmd_dst = 4'd3;
    step();
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL move_busy got=%b exp=1", busy); end
    checks++; if (r_in !== '0)   begin errors++; $display("[TB] FAIL move_r_in_k got=%h exp=0", r_in); end
    step();
    checks++; if (bus_out !== 32'h0000_1234 || bus_out !== m_bus) begin errors++; $display("[TB] FAIL move_bus got=%h exp=%h", bus_out, m_bus); end
    checks++; if (r_in !== '0) begin errors++; $display("[TB] FAIL move_r_in_k1 got=%h exp=0", r_in); end
    pc_q = $urandom;
    step();
    checks++; if (r_in !== 16'h0008) begin errors++; $display("[TB] FAIL move_r_in_k2 got=%h exp=0008", r_in); end
    checks++; if (done !== 1'b1)     begin errors++; $display("[TB] FAIL move_done_k2 got=%b exp=1", done); end
    step();
    checks++; if (r_in !== '0 || done !== 1'b0) begin errors++; $display("[TB] FAIL move_drop_k3 got r_in=%h done=%b exp 0/0", r_in, done); end
    checks++; if (bus_out !== 32'h0000_1234) begin errors++; $display("[TB] FAIL move_bus_hold got=%h exp=00001234", bus_out); end
    drain();
    checks++; if (env_regs[3] !== 32'h0000_1234) begin errors++; $display("[TB] FAIL move_regfile got=%h exp=00001234", env_regs[3]); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] srcs [3];
    logic [3:0] dsts [3];
    int idx;
    int done_cyc [$];
    logic [3:0] done_dst [$];
    for (int i = 0; i < 3; i++) begin
      srcs[i] = 5'($urandom_range(0, 23));
      dsts[i] = 4'(i * 5 + 1);
    end
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      randomize_specials();
      cmd_valid = (idx < 3);
      cmd_src   = srcs[idx < 3 ? idx : 2];
      cmd_dst   = dsts[idx < 3 ? idx : 2];
      step();
      if (m_pushed) idx++;
      checks++; if (cmd_ready !== (m_q.size() < DEPTH)) begin errors++; $display("[TB] FAIL b2b_ready cyc=%0d got=%b exp=%b", c, cmd_ready, m_q.size() < DEPTH); end
      checks++; if (bus_out !== m_bus) begin errors++; $display("[TB] FAIL b2b_bus cyc=%0d got=%h exp=%h", c, bus_out, m_bus); end
      checks++; if (r_in !== m_r_in || done !== m_done) begin errors++; $display("[TB] FAIL b2b_load cyc=%0d got=%h/%b exp=%h/%b", c, r_in, done, m_r_in, m_done); end
      if (done === 1'b1) begin
        done_cyc.push_back(c);
        for (int i = 0; i < 16; i++) if (r_in[i]) done_dst.push_back(4'(i));
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (done_cyc.size() != 3 || done_dst.size() != 3) begin
      errors++; $display("[TB] FAIL b2b_count got=%0d exp=3", done_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (done_dst[i] !== dsts[i]) begin errors++; $display("[TB] FAIL b2b_order i=%0d got=%0d exp=%0d", i, done_dst[i], dsts[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++; if (done_cyc[i] - done_cyc[i-1] != 3) begin errors++; $display("[TB] FAIL b2b_spacing i=%0d got=%0d exp=3", i, done_cyc[i] - done_cyc[i-1]); end
      end
    end
    drain();
  endtask

  task automatic test_raw_chain();
    set_reg(1, 32'hA5A5_0001);
    set_reg(2, $urandom);
    set_reg(5, $urandom);
    cmd_valid = 1'b1; cmd_src = 5'd1; cmd_dst = 4'd2;
    step();
    cmd_src = 5'd2; cmd_dst = 4'd5;
    step();
    checks++; if (m_pushed !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_second_push got ready=%b exp=1", cmd_ready); end
    cmd_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (bus_out !== m_bus || r_in !== m_r_in) begin errors++; $display("[TB] FAIL raw_cycle c=%0d got=%h/%h exp=%h/%h", c, bus_out, r_in, m_bus, m_r_in); end
    end
    drain();
    checks++; if (env_regs[5] !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL raw_r5 got=%h exp=a5a50001", env_regs[5]); end
    checks++; if (env_regs[2] !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL raw_r2 got=%h exp=a5a50001", env_regs[2]); end
  endtask

  task automatic test_invalid_src();
    err_clr = 1'b0;
    set_reg(7, 32'hFFFF_FFFF);
    cmd_valid = 1'b1; cmd_src = 5'd27; cmd_dst = 4'd7;
    step();
    cmd_valid = 1'b0;
    step();
    checks++; if (bus_out !== '0) begin errors++; $display("[TB] FAIL inv_bus got=%h exp=0", bus_out); end
    checks++; if (err !== 1'b1)   begin errors++; $display("[TB] FAIL inv_err_set got=%b exp=1", err); end
    step();
    checks++; if (r_in !== 16'h0080) begin errors++; $display("[TB] FAIL inv_r_in got=%h exp=0080", r_in); end
    step();
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL inv_err_sticky got=%b exp=1", err); end
    checks++; if (env_regs[7] !== '0) begin errors++; $display("[TB] FAIL inv_load_zero got=%h exp=0", env_regs[7]); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL inv_err_clear got=%b exp=0", err); end
    cmd_valid = 1'b1; cmd_src = 5'd27; cmd_dst = 4'd2;
    step();
    cmd_valid = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err !== 1'b1 || m_err !== 1'b1) begin errors++; $display("[TB] FAIL inv_set_wins got=%b exp=1", err); end
    drain();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err !== m_err) begin errors++; $display("[TB] FAIL inv_final_clear got=%b exp=%b", err, m_err); end
  endtask

  task automatic test_r0_macro();
    logic [DATA_W-1:0] exp_val;
`ifdef R0_ZERO_EN
    exp_val = '0;
`else
    exp_val = 32'hDEAD_BEEF;
`endif
    set_reg(0, 32'hDEAD_BEEF);
    cmd_valid = 1'b1; cmd_src = 5'd0; cmd_dst = 4'd4;
    step();
    cmd_valid = 1'b0;
    step();
    checks++; if (bus_out !== exp_val) begin errors++; $display("[TB] FAIL r0_bus got=%h exp=%h", bus_out, exp_val); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL r0_err got=%b exp=0", err); end
    drain();
    checks++; if (env_regs[4] !== exp_val) begin errors++; $display("[TB] FAIL r0_regfile got=%h exp=%h", env_regs[4], exp_val); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_src   = 5'($urandom_range(0, 23));
      cmd_dst   = 4'($urandom_range(0, 15));
      step();
    end
    cmd_valid = 1'b0;
    checks++; if (done !== 1'b1 || r_in !== m_r_in) begin errors++; $display("[TB] FAIL mid_in_load got=%h/%b exp=%h/1", r_in, done, m_r_in); end
    #2 clr = 1'b0;
    #1;
    checks++; if (r_in !== '0 || done !== 1'b0) begin errors++; $display("[TB] FAIL mid_drop got=%h/%b exp=0/0", r_in, done); end
    checks++; if (bus_out !== '0) begin errors++; $display("[TB] FAIL mid_bus got=%h exp=0", bus_out); end
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_status got ready=%b busy=%b exp 1/0", cmd_ready, busy); end
    step();
    clr = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (r_in !== '0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_discard c=%0d got=%h/%b/%b exp=0/0/0", c, r_in, done, busy); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      randomize_specials();
      if ($urandom_range(0, 7) == 0) set_reg(int'($urandom_range(0, 15)), $urandom);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_src   = 5'($urandom_range(0, 31));
      cmd_dst   = 4'($urandom_range(0, 15));
      err_clr   = ($urandom_range(0, 9) == 0);
      step();
      checks++; if (bus_out !== m_bus) begin errors++; $display("[TB] FAIL rand_bus c=%0d got=%h exp=%h", c, bus_out, m_bus); end
      checks++; if (r_in !== m_r_in || done !== m_done) begin errors++; $display("[TB] FAIL rand_load c=%0d got=%h/%b exp=%h/%b", c, r_in, done, m_r_in, m_done); end
      checks++; if (err !== m_err) begin errors++; $display("[TB] FAIL rand_err c=%0d got=%b exp=%b", c, err, m_err); end
      checks++; if (busy !== (m_phase != 0 || m_q.size() != 0)) begin errors++; $display("[TB] FAIL rand_busy c=%0d got=%b", c, busy); end
      checks++; if (cmd_ready !== (m_q.size() < DEPTH)) begin errors++; $display("[TB] FAIL rand_ready c=%0d got=%b", c, cmd_ready); end
    end
    err_clr = 1'b0;
    drain();
    for (int i = 0; i < 16; i++) begin
      checks++; if (env_regs[i] !== m_regs[i]) begin errors++; $display("[TB] FAIL rand_regfile r=%0d got=%h exp=%h", i, env_regs[i], m_regs[i]); end
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_single_move();
    test_back_to_back();
    test_raw_chain();
    test_invalid_src();
    test_r0_macro();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
